// File: rtl/conv_layer_seq.sv
// Layer sequencer for the conv engine: walks bias, weight-load and pixel-stream
// phases over every input/output channel group and tracks result write-back.
module conv_layer_seq #(
    parameter int FM_AW    = 13,
    parameter int WM_AW    = 10,
    parameter int BM_AW    = 9,
    parameter int LEN_W    = 9,
    parameter int GRP_W    = 8,
    parameter int SCALE_W  = 4,
    parameter int FLUSH_TO = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    input  logic               cfg_pw_mode,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic [LEN_W-1:0]   cfg_fm_len,
    input  logic [GRP_W-1:0]   cfg_in_grp,
    input  logic [GRP_W-1:0]   cfg_out_grp,
    input  logic [FM_AW-1:0]   cfg_rd_base,
    input  logic [FM_AW-1:0]   cfg_wr_base,
    input  logic               acc_valid_in,
    output logic               busy,
    output logic               done,
    output logic               err_flush,
    output logic               fm_rd_en,
    output logic [FM_AW-1:0]   fm_rd_addr,
    output logic               fm_wr_en,
    output logic [FM_AW-1:0]   fm_wr_addr,
    output logic               wm_rd_en,
    output logic [WM_AW-1:0]   wm_rd_addr,
    output logic [BM_AW-1:0]   bm_rd_addr,
    output logic               bias_out_valid,
    output logic               conv_data_valid_out,
    output logic               adder_rst,
    output logic               pw_mode,
    output logic [SCALE_W-1:0] conv_scale,
    output logic [LEN_W-1:0]   buff_len_ctrl,
    output logic               buff_len_rst
);
    localparam int FC_W = $clog2(FLUSH_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BIAS   = 3'd1,
        S_WLOAD  = 3'd2,
        S_STREAM = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t             state_r, state_s;
    logic [GRP_W-1:0]   og_r, og_s, ig_r, ig_s;
    logic [LEN_W-1:0]   p_r, p_s, wcnt_r;
    logic [3:0]         k_r, k_s;
    logic [WM_AW-1:0]   wptr_r, wptr_s;
    logic [FC_W-1:0]    fcnt_r, fcnt_s;
    logic               start_acc_s, timeout_s, bias_entry_s, cfg_zero_s, k_last_s;
    logic               last_pass_s, fm_rd_en_s;
    logic               pw_r, err_r, len_rst_r, cdv_r;
    logic [SCALE_W-1:0] scale_r;
    logic [LEN_W-1:0]   fm_len_r;
    logic [GRP_W-1:0]   in_grp_r, out_grp_r;
    logic [FM_AW-1:0]   rd_base_r, wr_base_r, rd_off_s, wr_off_s;

    assign cfg_zero_s = (cfg_fm_len == '0) || (cfg_in_grp == '0) || (cfg_out_grp == '0);
    assign k_last_s   = pw_r ? (k_r == 4'd0) : (k_r == 4'd8);

    // Next-state and counter-advance logic; hold freezes every active phase.
    always_comb begin
        state_s      = state_r;
        og_s         = og_r;
        ig_s         = ig_r;
        p_s          = p_r;
        k_s          = k_r;
        wptr_s       = wptr_r;
        fcnt_s       = fcnt_r;
        start_acc_s  = 1'b0;
        timeout_s    = 1'b0;
        bias_entry_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    og_s        = '0;
                    ig_s        = '0;
                    p_s         = '0;
                    k_s         = '0;
                    fcnt_s      = '0;
                    if (cfg_zero_s) begin
                        state_s = S_DONE;
                    end else begin
                        state_s      = S_BIAS;
                        bias_entry_s = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BIAS: begin
                if (hold) begin
                    state_s = S_BIAS;
                end else begin
                    state_s = S_WLOAD;
                    k_s     = '0;
                end
            end
            S_WLOAD: begin
                if (hold) begin
                    state_s = S_WLOAD;
                end else if (k_last_s) begin
                    wptr_s  = wptr_r + WM_AW'(1);
                    k_s     = '0;
                    p_s     = '0;
                    state_s = S_STREAM;
                end else begin
                    wptr_s = wptr_r + WM_AW'(1);
                    k_s    = k_r + 4'd1;
                end
            end
            S_STREAM: begin
                if (hold) begin
                    state_s = S_STREAM;
                end else if (p_r == fm_len_r - LEN_W'(1)) begin
                    p_s = '0;
                    if (ig_r == in_grp_r - GRP_W'(1)) begin
                        state_s = S_FLUSH;
                        fcnt_s  = '0;
                    end else begin
                        ig_s    = ig_r + GRP_W'(1);
                        state_s = S_WLOAD;
                    end
                end else begin
                    p_s = p_r + LEN_W'(1);
                end
            end
            S_FLUSH: begin
                if (hold) begin
                    state_s = S_FLUSH;
                end else if ((wcnt_r >= fm_len_r) || (fcnt_r == FC_W'(FLUSH_TO - 1))) begin
                    // a timeout is flagged but the layer still completes normally
                    timeout_s = (wcnt_r < fm_len_r);
                    ig_s      = '0;
                    fcnt_s    = '0;
                    if (og_r == out_grp_r - GRP_W'(1)) begin
                        state_s = S_DONE;
                    end else begin
                        og_s         = og_r + GRP_W'(1);
                        state_s      = S_BIAS;
                        bias_entry_s = 1'b1;
                    end
                end else begin
                    fcnt_s = fcnt_r + FC_W'(1);
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, group/pixel counters and the persistent weight pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            og_r    <= '0;
            ig_r    <= '0;
            p_r     <= '0;
            k_r     <= '0;
            wptr_r  <= '0;
            fcnt_r  <= '0;
        end else begin
            state_r <= state_s;
            og_r    <= og_s;
            ig_r    <= ig_s;
            p_r     <= p_s;
            k_r     <= k_s;
            wptr_r  <= wptr_s;
            fcnt_r  <= fcnt_s;
        end
    end

    // Layer configuration latched on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pw_r      <= 1'b0;
            scale_r   <= '0;
            fm_len_r  <= '0;
            in_grp_r  <= '0;
            out_grp_r <= '0;
            rd_base_r <= '0;
            wr_base_r <= '0;
        end else if (start_acc_s) begin
            pw_r      <= cfg_pw_mode;
            scale_r   <= cfg_scale;
            fm_len_r  <= cfg_fm_len;
            in_grp_r  <= cfg_in_grp;
            out_grp_r <= cfg_out_grp;
            rd_base_r <= cfg_rd_base;
            wr_base_r <= cfg_wr_base;
        end else begin
            pw_r <= pw_r;
        end
    end

    assign last_pass_s = ((state_r == S_STREAM) || (state_r == S_FLUSH)) &&
                         (ig_r == in_grp_r - GRP_W'(1));
    assign fm_wr_en    = acc_valid_in & last_pass_s;

    // Write-back counter keeps counting through hold so no result is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r <= '0;
        end else if (start_acc_s || bias_entry_s) begin
            wcnt_r <= '0;
        end else if (fm_wr_en) begin
            wcnt_r <= wcnt_r + LEN_W'(1);
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Sticky timeout flag, line-buffer reset pulse and read-data valid delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r     <= 1'b0;
            len_rst_r <= 1'b0;
            cdv_r     <= 1'b0;
        end else begin
            if (start_acc_s) begin
                err_r <= 1'b0;
            end else if (timeout_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            len_rst_r <= start_acc_s;
            cdv_r     <= fm_rd_en_s;
        end
    end

    assign rd_off_s   = FM_AW'(32'(ig_r) * 32'(fm_len_r) + 32'(p_r));
    assign wr_off_s   = FM_AW'(32'(og_r) * 32'(fm_len_r) + 32'(wcnt_r));
    assign fm_rd_en_s = (state_r == S_STREAM) && !hold;

    assign busy                = (state_r != S_IDLE) && (state_r != S_DONE);
    assign done                = (state_r == S_DONE);
    assign err_flush           = err_r;
    assign fm_rd_en            = fm_rd_en_s;
    assign fm_rd_addr          = rd_base_r + rd_off_s;
    assign fm_wr_addr          = wr_base_r + wr_off_s;
    assign wm_rd_en            = (state_r == S_WLOAD) && !hold;
    assign wm_rd_addr          = wptr_r;
    assign bm_rd_addr          = BM_AW'(og_r);
    assign bias_out_valid      = (state_r == S_BIAS) && !hold;
    assign conv_data_valid_out = cdv_r;
    assign adder_rst           = (state_r == S_STREAM) && (ig_r == '0);
    assign pw_mode             = pw_r;
    assign conv_scale          = scale_r;
    assign buff_len_ctrl       = fm_len_r;
    assign buff_len_rst        = len_rst_r;
endmodule
